kbd_event_ctrl: RTL

Sequencer for the PS/2 receiver: pulls scan-code bytes out of the `ps2_keyboard` FIFO with the `ready`/`nextdata_n` handshake and parses `E0` (extended) and `F0` (break) prefixes. Emits one clean key event per make/break code, tracks the currently held key and counts key presses. Sits between `ps2_keyboard` and the display/ASCII logic and replaces ad-hoc edge-detect FSMs in top-level wrappers.

---
 rtl/kbd_event_ctrl_if.sv | 37 +++
 rtl/kbd_event_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/kbd_event_ctrl_if.sv
// rtl/kbd_event_ctrl_if.sv - receiver-side handshake and key-event bundle for kbd_event_ctrl
//
// Purpose: groups the PS/2 receiver FIFO handshake and the key-event strobe
//          into one bundle so the sequencer and its neighbours share a single port.
// Signals:
//   kb_ready      receiver FIFO non-empty
//   kb_data       receiver FIFO head byte
//   kb_overflow   receiver overflow flag
//   kb_nextdata_n active-low pop strobe back to the receiver
//   evt_valid     one-cycle key event strobe
//   evt_code      scan code of the last event (held between events)
//   evt_ext       last event was E0-prefixed
//   evt_break     last event was a release (F0-prefixed)
// Modports:
//   master  the sequencer (consumes FIFO bytes, produces events)
//   slave   the receiver/consumer side

interface kbd_event_ctrl_if;
   logic       kb_ready;
   logic [7:0] kb_data;
   logic       kb_overflow;
   logic       kb_nextdata_n;
   logic       evt_valid;
   logic [7:0] evt_code;
   logic       evt_ext;
   logic       evt_break;

   modport master (
      input  kb_ready, kb_data, kb_overflow,
      output kb_nextdata_n, evt_valid, evt_code, evt_ext, evt_break
   );

   modport slave (
      output kb_ready, kb_data, kb_overflow,
      input  kb_nextdata_n, evt_valid, evt_code, evt_ext, evt_break
   );
endinterface

// File: rtl/kbd_event_ctrl.sv
// rtl/kbd_event_ctrl.sv - PS/2 scan-code sequencer producing clean make/break key events
//
// Purpose: pops bytes from the ps2_keyboard FIFO (IDLE -> POP -> GAP), parses
//          E0/F0 prefixes, emits one event per make/break code, tracks the
//          held key, counts make events and records receiver overflow.
// Parameters:
//   CNT_W    width of key_count
//   TIMEOUT  idle cycles after which a pending prefix is dropped (>= 2)
// Ports:
//   clk          clock
//   clr          asynchronous active-high reset
//   kb           kbd_event_ctrl_if.master (FIFO handshake + event outputs)
//   held_code    last pressed, unreleased key (0 = none)
//   held_ext     extended flag of held_code
//   key_count    make events emitted, modulo 2^CNT_W
//   err_overflow sticky receiver overflow flag
//   err_clr      clears err_overflow (overflow set has priority)
// Build option:
//   KBD_TYPEMATIC_FILTER_EN  suppress make events that repeat the held key

module kbd_event_ctrl #(
   parameter int CNT_W   = 8,
   parameter int TIMEOUT = 1_000_000
) (
   input  logic                 clk,
   input  logic                 clr,
   kbd_event_ctrl_if.master     kb,
   output logic [7:0]           held_code,
   output logic                 held_ext,
   output logic [CNT_W-1:0]     key_count,
   output logic                 err_overflow,
   input  logic                 err_clr
);

   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {S_IDLE, S_POP, S_GAP} state_t;

   state_t           state_q, state_d;
   logic [7:0]       byte_q, byte_d;
   logic             ext_pend_q, ext_pend_d;
   logic             brk_pend_q, brk_pend_d;
   logic [TW-1:0]    tmo_q, tmo_d;
   logic             nextdata_n_q, nextdata_n_d;
   logic             evt_valid_q, evt_valid_d;
   logic [7:0]       evt_code_q, evt_code_d;
   logic             evt_ext_q, evt_ext_d;
   logic             evt_break_q, evt_break_d;
   logic [7:0]       held_code_q, held_code_d;
   logic             held_ext_q, held_ext_d;
   logic [CNT_W-1:0] key_count_q, key_count_d;
   logic             err_q, err_d;

   logic             held_match;
   logic             repeat_hit;

   // Current byte with its pending ext flag names the key already held.
   assign held_match = (byte_q == held_code_q) && (ext_pend_q == held_ext_q);

`ifdef KBD_TYPEMATIC_FILTER_EN
   assign repeat_hit = held_match;
`else
   assign repeat_hit = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or posedge clr) begin
      if (clr) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (kb.kb_ready) state_d = S_POP;
         S_POP:   state_d = S_GAP;
         S_GAP:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Output / datapath next-state logic
   always_comb begin
      byte_d       = byte_q;
      ext_pend_d   = ext_pend_q;
      brk_pend_d   = brk_pend_q;
      tmo_d        = tmo_q;
      // Registered strobe: low for exactly the cycle spent in POP.
      nextdata_n_d = (state_d != S_POP);
      evt_valid_d  = 1'b0;
      evt_code_d   = evt_code_q;
      evt_ext_d    = evt_ext_q;
      evt_break_d  = evt_break_q;
      held_code_d  = held_code_q;
      held_ext_d   = held_ext_q;
      key_count_d  = key_count_q;
      err_d        = err_q;

      case (state_q)
         S_IDLE: begin
            if (kb.kb_ready) begin
               byte_d = kb.kb_data;
               tmo_d  = '0;
            end else if (ext_pend_q || brk_pend_q) begin
               // Counter only advances while a prefix is waiting on an empty FIFO.
               if (tmo_q == TW'(TIMEOUT - 1)) begin
                  ext_pend_d = 1'b0;
                  brk_pend_d = 1'b0;
                  tmo_d      = '0;
               end else begin
                  tmo_d = tmo_q + TW'(1);
               end
            end
         end
         S_POP: begin
            if (byte_q == 8'hE0) begin
               ext_pend_d = 1'b1;
            end else if (byte_q == 8'hF0) begin
               brk_pend_d = 1'b1;
            end else begin
               ext_pend_d = 1'b0;
               brk_pend_d = 1'b0;
               if (brk_pend_q) begin
                  evt_valid_d = 1'b1;
                  evt_code_d  = byte_q;
                  evt_ext_d   = ext_pend_q;
                  evt_break_d = 1'b1;
                  // Releasing some other key leaves the held key alone.
                  if (held_match) begin
                     held_code_d = 8'h00;
                     held_ext_d  = 1'b0;
                  end
               end else if (!repeat_hit) begin
                  evt_valid_d = 1'b1;
                  evt_code_d  = byte_q;
                  evt_ext_d   = ext_pend_q;
                  evt_break_d = 1'b0;
                  held_code_d = byte_q;
                  held_ext_d  = ext_pend_q;
                  key_count_d = key_count_q + CNT_W'(1);
               end
            end
         end
         default: ;
      endcase

      // Lost bytes make any pending prefix meaningless.
      if (kb.kb_overflow) begin
         ext_pend_d = 1'b0;
         brk_pend_d = 1'b0;
         tmo_d      = '0;
      end

      if (kb.kb_overflow) err_d = 1'b1;
      else if (err_clr)   err_d = 1'b0;
   end

   // Datapath registers
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         byte_q       <= 8'h00;
         ext_pend_q   <= 1'b0;
         brk_pend_q   <= 1'b0;
         tmo_q        <= '0;
         nextdata_n_q <= 1'b1;
         evt_valid_q  <= 1'b0;
         evt_code_q   <= 8'h00;
         evt_ext_q    <= 1'b0;
         evt_break_q  <= 1'b0;
         held_code_q  <= 8'h00;
         held_ext_q   <= 1'b0;
         key_count_q  <= '0;
         err_q        <= 1'b0;
      end else begin
         byte_q       <= byte_d;
         ext_pend_q   <= ext_pend_d;
         brk_pend_q   <= brk_pend_d;
         tmo_q        <= tmo_d;
         nextdata_n_q <= nextdata_n_d;
         evt_valid_q  <= evt_valid_d;
         evt_code_q   <= evt_code_d;
         evt_ext_q    <= evt_ext_d;
         evt_break_q  <= evt_break_d;
         held_code_q  <= held_code_d;
         held_ext_q   <= held_ext_d;
         key_count_q  <= key_count_d;
         err_q        <= err_d;
      end
   end

   assign kb.kb_nextdata_n = nextdata_n_q;
   assign kb.evt_valid     = evt_valid_q;
   assign kb.evt_code      = evt_code_q;
   assign kb.evt_ext       = evt_ext_q;
   assign kb.evt_break     = evt_break_q;
   assign held_code        = held_code_q;
   assign held_ext         = held_ext_q;
   assign key_count        = key_count_q;
   assign err_overflow     = err_q;

endmodule
